// File: rtl/veritune_pkg.sv
// Shared veritune definitions: bus width defaults and the peak reader state encoding.
package veritune_pkg;

    localparam int unsigned VtAddrW = 10;
    localparam int unsigned VtDataW = 16;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StScan = 2'd1,
        StDone = 2'd2
    } vt_state_t;

endpackage

// File: rtl/veritune_abs_sat.sv
// Combinational absolute value of a signed word; the most negative value saturates to max positive.
module veritune_abs_sat #(
    parameter int unsigned W = 16
) (
    input  logic signed [W-1:0] x,
    output logic        [W-1:0] mag
);

    localparam logic [W-1:0] MinNeg = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] MaxPos = {1'b0, {(W-1){1'b1}}};

    always_comb begin
        mag = x;
        if (x == MinNeg) begin
            mag = MaxPos;
        end else if (x[W-1]) begin
            mag = -x;
        end
    end

endmodule

// File: rtl/veritune_peak_reader.sv
// Sweeps the positive-frequency FFT bins after Done and reports the bin with the largest
// absolute real part through a valid/ack handshake.
module veritune_peak_reader
    import veritune_pkg::*;
#(
    parameter int unsigned ADDR_W  = VtAddrW,
    parameter int unsigned DATA_W  = VtDataW,
    parameter int unsigned N_BINS  = 512,
    parameter int unsigned MIN_BIN = 1
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     Fft_done,
    output logic [ADDR_W-1:0]        Addr_Rd,
    input  logic signed [DATA_W-1:0] Data_rout,
    output logic                     Peak_valid,
    output logic [ADDR_W-1:0]        Peak_bin,
    output logic [DATA_W-1:0]        Peak_mag,
    input  logic                     Peak_ack,
    output logic                     Busy
);

    localparam logic [ADDR_W-1:0] FirstBin = ADDR_W'(MIN_BIN);
    localparam logic [ADDR_W-1:0] LastBin  = ADDR_W'(N_BINS - 1);

    vt_state_t         state_q, state_d;
    logic              done_q;
    logic              start;
    logic [DATA_W-1:0] mag;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] best_mag_q, best_mag_d;
    logic [ADDR_W-1:0] best_bin_q, best_bin_d;
    logic [DATA_W-1:0] peak_mag_q, peak_mag_d;
    logic [ADDR_W-1:0] peak_bin_q, peak_bin_d;
    logic              upd;
    logic [DATA_W-1:0] scan_mag;
    logic [ADDR_W-1:0] scan_bin;

    veritune_abs_sat #(
        .W(DATA_W)
    ) u_abs_sat (
        .x  (Data_rout),
        .mag(mag)
    );

    assign start = Fft_done & ~done_q;

    // Strict compare so ties keep the lower (earlier) bin.
    assign upd      = mag > best_mag_q;
    assign scan_mag = upd ? mag : best_mag_q;
    assign scan_bin = upd ? addr_q : best_bin_q;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        best_mag_d = best_mag_q;
        best_bin_d = best_bin_q;
        peak_mag_d = peak_mag_q;
        peak_bin_d = peak_bin_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d    = StScan;
                    addr_d     = FirstBin;
                    best_mag_d = '0;
                    best_bin_d = FirstBin;
                end
            end
            StScan: begin
                best_mag_d = scan_mag;
                best_bin_d = scan_bin;
                if (addr_q == LastBin) begin
                    state_d    = StDone;
                    addr_d     = '0;
                    peak_mag_d = scan_mag;
                    peak_bin_d = scan_bin;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            StDone: begin
                if (Peak_ack) begin
                    if (start) begin
                        state_d    = StScan;
                        addr_d     = FirstBin;
                        best_mag_d = '0;
                        best_bin_d = FirstBin;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // done_q resets high so a Done level present at reset release is not seen as an edge.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q    <= StIdle;
            done_q     <= 1'b1;
            addr_q     <= '0;
            best_mag_q <= '0;
            best_bin_q <= '0;
            peak_mag_q <= '0;
            peak_bin_q <= '0;
        end else begin
            state_q    <= state_d;
            done_q     <= Fft_done;
            addr_q     <= addr_d;
            best_mag_q <= best_mag_d;
            best_bin_q <= best_bin_d;
            peak_mag_q <= peak_mag_d;
            peak_bin_q <= peak_bin_d;
        end
    end

    assign Addr_Rd    = addr_q;
    assign Peak_bin   = peak_bin_q;
    assign Peak_mag   = peak_mag_q;
    assign Peak_valid = (state_q == StDone);
    assign Busy       = (state_q == StScan);

endmodule

// File: tb/tb_veritune_peak_reader.sv
// Directed bench for veritune_peak_reader: table of bin patterns plus handshake/reset sequences.
module tb_veritune_peak_reader;

    localparam int ADDR_W  = 10;
    localparam int DATA_W  = 16;
    localparam int N_BINS  = 512;
    localparam int MIN_BIN = 1;
    localparam int SCAN_LEN = N_BINS - MIN_BIN;

    logic                     Clk;
    logic                     Reset;
    logic                     Fft_done;
    logic [ADDR_W-1:0]        Addr_Rd;
    logic signed [DATA_W-1:0] Data_rout;
    logic                     Peak_valid;
    logic [ADDR_W-1:0]        Peak_bin;
    logic [DATA_W-1:0]        Peak_mag;
    logic                     Peak_ack;
    logic                     Busy;

    logic signed [DATA_W-1:0] mem [1024];

    int checks;
    int failures;

    veritune_peak_reader #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .N_BINS (N_BINS),
        .MIN_BIN(MIN_BIN)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Fft_done  (Fft_done),
        .Addr_Rd   (Addr_Rd),
        .Data_rout (Data_rout),
        .Peak_valid(Peak_valid),
        .Peak_bin  (Peak_bin),
        .Peak_mag  (Peak_mag),
        .Peak_ack  (Peak_ack),
        .Busy      (Busy)
    );

    assign Data_rout = mem[Addr_Rd];

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        int b0; int v0;
        int b1; int v1;
        int b2; int v2;
        bit noise;
        int exp_bin;
        int exp_mag;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic load(input vec_t v);
        for (int i = 0; i < 1024; i++) begin
            mem[i] = v.noise ? 16'(((i * 37) % 101) - 50) : 16'sd0;
        end
        if (v.b0 >= 0) mem[v.b0] = 16'(v.v0);
        if (v.b1 >= 0) mem[v.b1] = 16'(v.v1);
        if (v.b2 >= 0) mem[v.b2] = 16'(v.v2);
    endtask

    // Leaves the bench at the negedge of the first SCAN cycle.
    task automatic start_scan();
        @(negedge Clk);
        Fft_done = 1'b1;
        @(negedge Clk);
        Fft_done = 1'b0;
    endtask

    // Called on a negedge inside SCAN; returns at the first negedge after Busy drops.
    task automatic wait_scan(input bit poke_ack, output int cycles, output int addr_bad);
        cycles   = 0;
        addr_bad = 0;
        while (Busy && cycles < 2000) begin
            if (int'(Addr_Rd) != MIN_BIN + cycles) addr_bad++;
            cycles++;
            Peak_ack = poke_ack && cycles >= 10 && cycles < 13;
            @(negedge Clk);
        end
        Peak_ack = 1'b0;
    endtask

    task automatic ack_result(input string name);
        Peak_ack = 1'b1;
        @(negedge Clk);
        Peak_ack = 1'b0;
        check({name, " valid after ack"}, int'(Peak_valid), 0);
        check({name, " busy after ack"}, int'(Busy), 0);
    endtask

    initial begin
        int cycles;
        int addr_bad;
        int bad;
        checks   = 0;
        failures = 0;
        Reset    = 1'b0;
        Fft_done = 1'b0;
        Peak_ack = 1'b0;

        vecs[0] = '{b0:37,  v0:1200,   b1:-1,  v1:0,    b2:-1,  v2:0,    noise:1,
                    exp_bin:37,  exp_mag:1200};
        vecs[1] = '{b0:100, v0:-2000,  b1:200, v1:1500, b2:-1,  v2:0,    noise:1,
                    exp_bin:100, exp_mag:2000};
        vecs[2] = '{b0:5,   v0:-32768, b1:-1,  v1:0,    b2:-1,  v2:0,    noise:1,
                    exp_bin:5,   exp_mag:32767};
        vecs[3] = '{b0:20,  v0:900,    b1:300, v1:900,  b2:0,   v2:30000, noise:1,
                    exp_bin:20,  exp_mag:900};
        vecs[4] = '{b0:-1,  v0:0,      b1:-1,  v1:0,    b2:-1,  v2:0,    noise:0,
                    exp_bin:1,   exp_mag:0};
        vecs[5] = '{b0:511, v0:-700,   b1:512, v1:5000, b2:-1,  v2:0,    noise:1,
                    exp_bin:511, exp_mag:700};
        load(vecs[0]);

        #12;
        check("reset addr", int'(Addr_Rd), 0);
        check("reset valid", int'(Peak_valid), 0);
        check("reset busy", int'(Busy), 0);
        check("reset bin", int'(Peak_bin), 0);
        check("reset mag", int'(Peak_mag), 0);
        @(negedge Clk);
        Reset = 1'b1;
        repeat (2) @(negedge Clk);

        for (int k = 0; k < 6; k++) begin
            load(vecs[k]);
            start_scan();
            wait_scan(k == 1, cycles, addr_bad);
            check($sformatf("vec%0d scan length", k), cycles, SCAN_LEN);
            check($sformatf("vec%0d addr trace errors", k), addr_bad, 0);
            check($sformatf("vec%0d valid", k), int'(Peak_valid), 1);
            check($sformatf("vec%0d bin", k), int'(Peak_bin), vecs[k].exp_bin);
            check($sformatf("vec%0d mag", k), int'(Peak_mag), vecs[k].exp_mag);
            check($sformatf("vec%0d addr in done", k), int'(Addr_Rd), 0);
            ack_result($sformatf("vec%0d", k));
            @(negedge Clk);
        end

        // Result must stay put while unacknowledged even with Done edges arriving.
        load(vecs[0]);
        start_scan();
        wait_scan(1'b0, cycles, addr_bad);
        bad = 0;
        for (int c = 0; c < 50; c++) begin
            Fft_done = ~Fft_done;
            @(negedge Clk);
            if (!Peak_valid || Busy || Peak_bin != 10'd37 || Peak_mag != 16'd1200 ||
                Addr_Rd != '0) bad++;
        end
        Fft_done = 1'b0;
        @(negedge Clk);
        check("hold in done unstable cycles", bad, 0);
        ack_result("hold");
        @(negedge Clk);
        check("idle after hold", int'(Busy) + int'(Peak_valid), 0);

        // Done already high at reset release must not start a scan.
        Reset    = 1'b0;
        Fft_done = 1'b1;
        #3;
        @(negedge Clk);
        Reset = 1'b1;
        bad   = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge Clk);
            if (Busy) bad++;
        end
        check("done high at release busy cycles", bad, 0);
        Fft_done = 1'b0;
        @(negedge Clk);

        // Ack and a fresh Done edge together restart immediately.
        load(vecs[1]);
        start_scan();
        wait_scan(1'b0, cycles, addr_bad);
        check("pre-restart valid", int'(Peak_valid), 1);
        load(vecs[2]);
        Peak_ack = 1'b1;
        Fft_done = 1'b1;
        @(negedge Clk);
        Peak_ack = 1'b0;
        Fft_done = 1'b0;
        check("restart busy", int'(Busy), 1);
        check("restart valid", int'(Peak_valid), 0);
        check("restart addr", int'(Addr_Rd), 1);
        wait_scan(1'b0, cycles, addr_bad);
        check("restart scan length", cycles, SCAN_LEN);
        check("restart bin", int'(Peak_bin), 5);
        check("restart mag", int'(Peak_mag), 32767);
        ack_result("restart");

        // Reset in mid-scan discards the partial result.
        load('{b0:100, v0:9000, b1:-1, v1:0, b2:-1, v2:0, noise:1, exp_bin:100, exp_mag:9000});
        start_scan();
        cycles = 0;
        while (int'(Addr_Rd) != 250 && cycles < 2000) begin
            cycles++;
            @(negedge Clk);
        end
        check("reached addr 250", int'(Addr_Rd), 250);
        Reset = 1'b0;
        #1;
        check("mid reset addr", int'(Addr_Rd), 0);
        check("mid reset busy", int'(Busy), 0);
        check("mid reset valid", int'(Peak_valid), 0);
        check("mid reset bin", int'(Peak_bin), 0);
        check("mid reset mag", int'(Peak_mag), 0);
        @(negedge Clk);
        Reset = 1'b1;
        load('{b0:400, v0:3333, b1:-1, v1:0, b2:-1, v2:0, noise:1, exp_bin:400, exp_mag:3333});
        @(negedge Clk);
        start_scan();
        wait_scan(1'b0, cycles, addr_bad);
        check("post reset scan length", cycles, SCAN_LEN);
        check("post reset bin", int'(Peak_bin), 400);
        check("post reset mag", int'(Peak_mag), 3333);
        ack_result("post reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
